// File: rtl/be_mem_arbiter_pkg.sv
// Shared types for the back-end memory port arbiter.
package be_mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single-entry vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/be_mem_arbiter_rr.sv
// Round-robin priority encoder: rotate requests by ptr, pick lowest set bit, rotate index back.
module rr_priority_enc
  import be_mem_arbiter_pkg::*;
#(
  parameter  int unsigned N = 2,
  localparam int unsigned W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [N-1:0] rot;

  always_comb begin
    int unsigned sel;
    logic        found;
    rot   = '0;
    sel   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = req[(i + 32'(ptr)) % N];
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        sel   = i;
      end
    end
    gnt_idx = W'((sel + 32'(ptr)) % N);
    any     = |req;
  end

endmodule

// File: rtl/be_mem_arbiter.sv
// Shares one native memory port among N_MASTERS cache back-ends with round-robin,
// burst-locked grants of up to MAX_BURST transfers.
module be_mem_arbiter
  import be_mem_arbiter_pkg::*;
#(
  parameter  int unsigned N_MASTERS = 2,
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned MAX_BURST = 8,
  localparam int unsigned NBYTES    = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MASTERS-1:0]        s_valid,
  input  logic [N_MASTERS*ADDR_W-1:0] s_addr,
  input  logic [N_MASTERS*DATA_W-1:0] s_wdata,
  input  logic [N_MASTERS*NBYTES-1:0] s_wstrb,
  output logic [N_MASTERS*DATA_W-1:0] s_rdata,
  output logic [N_MASTERS-1:0]        s_ready,
  output logic                        mem_valid,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [NBYTES-1:0]           mem_wstrb,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready
);

  localparam int unsigned M_W   = idx_w(N_MASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state, state_n;
  logic [M_W-1:0]   grant, grant_n, rr_ptr, rr_n, enc_idx, next_ptr;
  logic [CNT_W-1:0] burst_cnt, cnt_n;
  logic             enc_any;

  rr_priority_enc #(.N(N_MASTERS)) u_enc (
    .req    (s_valid),
    .ptr    (rr_ptr),
    .gnt_idx(enc_idx),
    .any    (enc_any)
  );

  assign next_ptr = (grant == M_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
  assign s_rdata  = {N_MASTERS{mem_rdata}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      rr_ptr    <= rr_n;
      burst_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    rr_n    = rr_ptr;
    cnt_n   = burst_cnt;
    case (state)
      ARB_IDLE: begin
        if (enc_any) begin
          grant_n = enc_idx;
          cnt_n   = '0;
          state_n = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A dropped valid ends the burst even mid-transfer, so a misbehaving master cannot hold the port.
        if (!s_valid[grant]) begin
          state_n = ARB_IDLE;
          rr_n    = next_ptr;
        end else if (mem_ready) begin
          cnt_n = burst_cnt + 1'b1;
          if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            state_n = ARB_IDLE;
            rr_n    = next_ptr;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, even if the state register is still BUSY.
  always_comb begin
    int unsigned gi;
    gi        = 32'(grant);
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    s_ready   = '0;
    if (state == ARB_BUSY && !reset) begin
      mem_valid      = s_valid[grant];
      mem_addr       = s_addr[gi*ADDR_W +: ADDR_W];
      mem_wdata      = s_wdata[gi*DATA_W +: DATA_W];
      mem_wstrb      = s_wstrb[gi*NBYTES +: NBYTES];
      s_ready[grant] = mem_ready;
    end
  end

endmodule

// File: tb/tb_be_mem_arbiter.sv
// Directed bench for be_mem_arbiter (2 masters) plus a randomised 3-master fairness run.
module tb_be_mem_arbiter;

  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  s_valid;
  logic [63:0] s_addr, s_wdata, s_rdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_ready;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic [2:0]  r_s_valid, r_s_ready;
  logic [95:0] r_s_addr, r_s_wdata, r_s_rdata;
  logic [11:0] r_s_wstrb;
  logic        r_mem_valid, r_mem_ready;
  logic [31:0] r_mem_addr, r_mem_wdata, r_mem_rdata;
  logic [3:0]  r_mem_wstrb;

  int checks = 0;
  int errors = 0;
  int rsp_delay = 0;
  int grants = 0;
  int total3 = 0;
  int log_q[$];

  always #5 clk = ~clk;

  be_mem_arbiter dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  be_mem_arbiter #(.N_MASTERS(3), .MAX_BURST(4)) dut3 (
    .clk(clk), .reset(reset), .s_valid(r_s_valid), .s_addr(r_s_addr), .s_wdata(r_s_wdata),
    .s_wstrb(r_s_wstrb), .s_rdata(r_s_rdata), .s_ready(r_s_ready), .mem_valid(r_mem_valid),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_wstrb(r_mem_wstrb),
    .mem_rdata(r_mem_rdata), .mem_ready(r_mem_ready)
  );

  // Memory models: ready after rsp_delay wait cycles, data = addr ^ KEY.
  initial begin
    int wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_ready = 1'b0;
      if (mem_valid) begin
        if (wcnt >= rsp_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr ^ KEY;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  initial begin
    int wcnt = 0;
    int rd = 0;
    r_mem_ready = 1'b0;
    r_mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      r_mem_ready = 1'b0;
      if (r_mem_valid) begin
        if (wcnt >= rd) begin
          r_mem_ready = 1'b1;
          r_mem_rdata = r_mem_addr ^ KEY;
          wcnt = 0;
          rd = $urandom_range(5, 0);
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    if (r_mem_valid && r_mem_ready) total3++;
  end

  // Per-cycle monitor: ready one-hot and qualified by mem_ready, service log, grant count.
  initial begin
    logic prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      checks++;
      if ($countones(s_ready) > 1 || (s_ready != 2'b00 && !mem_ready)) begin
        errors++;
        $display("FAIL ready_onehot s_ready=%b mem_ready=%b want at most one bit, only with mem_ready", s_ready, mem_ready);
      end
      checks++;
      if ($countones(r_s_ready) > 1 || (r_s_ready != 3'b000 && !r_mem_ready)) begin
        errors++;
        $display("FAIL ready_onehot3 s_ready=%b mem_ready=%b want at most one bit", r_s_ready, r_mem_ready);
      end
      if (mem_valid && mem_ready) log_q.push_back(s_ready[1] ? 1 : 0);
      if (mem_valid && !prev_mv) grants++;
      prev_mv = mem_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_burst(input int m, input logic [31:0] base, input int n,
                          input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] a;
    bit done;
    int budget;
    for (int k = 0; k < n; k++) begin
      a = base + 32'(4 * k);
      s_addr[m*32 +: 32]  = a;
      s_wdata[m*32 +: 32] = wd + 32'(k);
      s_wstrb[m*4 +: 4]   = strb;
      s_valid[m]          = 1'b1;
      done = 0;
      budget = 0;
      while (!done && budget < 200) begin
        @(negedge clk);
        if (s_ready[m]) begin
          done = 1;
          if (strb == 4'b0000) begin
            checks++;
            if (s_rdata[m*32 +: 32] !== (a ^ KEY)) begin
              errors++;
              $display("FAIL rdata m%0d addr=%h got=%h want=%h", m, a, s_rdata[m*32 +: 32], a ^ KEY);
            end
          end
        end
        budget++;
        @(posedge clk); #1;
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL timeout m%0d addr=%h got=no_ready want=ready", m, a);
      end
    end
    s_valid[m]        = 1'b0;
    s_wstrb[m*4 +: 4] = '0;
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len got=%0d want=%0d", name, log_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (log_q[i] != exp_q[i]) begin
          errors++;
          $display("FAIL %s[%0d] got=m%0d want=m%0d", name, i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    s_valid = 2'b01;
    s_addr = 64'h100;
    s_wdata = '0;
    s_wstrb = 8'h0F;
    r_s_valid = '0;
    r_s_addr = '0;
    r_s_wdata = '0;
    r_s_wstrb = '0;
    idle(2);
    @(negedge clk);
    checks++;
    if ({mem_valid, s_ready, mem_addr, mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_hold got=v%b r%b a%h s%h want=all zero", mem_valid, s_ready, mem_addr, mem_wstrb);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    s_valid = '0;
    s_addr = '0;
    s_wstrb = '0;
    @(negedge clk);
    checks++;
    if ({mem_valid, s_ready, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_after got=v%b r%b a%h want=all zero", mem_valid, s_ready, mem_addr);
    end
    idle(1);
  endtask

  task automatic test_single;
    int exp_q[$];
    rsp_delay = 1;
    idle(2);
    log_q.delete();
    grants = 0;
    fork
      do_burst(0, 32'h100, 8, 32'h0, 4'b0000);
      begin
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_idle got=%b want=0", mem_valid);
        end
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h100) begin
          errors++;
          $display("FAIL latency_grant got=v%b a%h want=v1 a00000100", mem_valid, mem_addr);
        end
      end
    join
    for (int i = 0; i < 8; i++) exp_q.push_back(0);
    check_log("single", exp_q);
    checks++;
    if (grants != 1) begin
      errors++;
      $display("FAIL single_grants got=%0d want=1", grants);
    end
  endtask

  task automatic test_contention;
    int exp_q[$];
    rsp_delay = 0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    log_q.delete();
    fork
      do_burst(0, 32'h200, 2, 32'h0, 4'b0000);
      do_burst(1, 32'h300, 2, 32'h0, 4'b0000);
    join
    exp_q = '{0, 0, 1, 1};
    check_log("contention", exp_q);
    idle(2);
    log_q.delete();
    fork
      do_burst(0, 32'h240, 1, 32'h0, 4'b0000);
      do_burst(1, 32'h340, 1, 32'h0, 4'b0000);
    join
    exp_q = '{0, 1};
    check_log("contention_rr", exp_q);
  endtask

  task automatic test_burst_cap;
    int exp_q[$];
    rsp_delay = 0;
    idle(2);
    log_q.delete();
    fork
      do_burst(0, 32'h400, 12, 32'h0, 4'b0000);
      do_burst(1, 32'h500, 2, 32'h0, 4'b0000);
    join
    for (int i = 0; i < 14; i++) exp_q.push_back((i >= 8 && i < 10) ? 1 : 0);
    check_log("burst_cap", exp_q);
  endtask

  task automatic test_wstrb;
    int exp_q[$];
    rsp_delay = 2;
    idle(2);
    log_q.delete();
    fork
      do_burst(1, 32'h40, 1, 32'hDEADBEEF, 4'b0011);
      begin
        int b = 0;
        @(negedge clk);
        while (!mem_valid && b < 10) begin
          @(negedge clk);
          b++;
        end
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'b0011) begin
          errors++;
          $display("FAIL wstrb_mux got=v%b a%h d%h s%b want=v1 a00000040 ddeadbeef s0011",
                   mem_valid, mem_addr, mem_wdata, mem_wstrb);
        end
      end
    join
    exp_q = '{1};
    check_log("wstrb", exp_q);
  endtask

  task automatic test_reset_mid;
    int cnt = 0;
    int budget = 0;
    rsp_delay = 0;
    idle(2);
    do_burst(0, 32'h600, 1, 32'h0, 4'b0000);
    idle(2);
    s_addr[63:32] = 32'h700;
    s_valid[1] = 1'b1;
    while (cnt < 2 && budget < 50) begin
      @(negedge clk);
      if (s_ready[1]) cnt++;
      budget++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 2) begin
      errors++;
      $display("FAIL reset_mid_setup got=%0d want=2 transfers", cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || s_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_during got=v%b r%b want=v0 r00", mem_valid, s_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    s_addr[31:0] = 32'h680;
    s_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || s_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_after got=v%b r%b want=v0 r00", mem_valid, s_ready);
    end
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h680 || s_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_first got=v%b a%h r%b want=v1 a00000680 r01", mem_valid, mem_addr, s_ready);
    end
    @(posedge clk); #1;
    s_valid = 2'b00;
    idle(3);
  endtask

  task automatic rmaster(input int m);
    logic [31:0] a;
    bit done;
    int budget, snap, len;
    for (int b = 0; b < 5; b++) begin
      idle($urandom_range(3, 0));
      len = $urandom_range(6, 1);
      for (int k = 0; k < len; k++) begin
        a = 32'((m + 1) * 4096 + b * 64 + k * 4);
        r_s_addr[m*32 +: 32] = a;
        r_s_valid[m] = 1'b1;
        snap = total3;
        done = 0;
        budget = 0;
        while (!done && budget < 400) begin
          @(negedge clk);
          if (r_s_ready[m]) begin
            done = 1;
            checks++;
            if (r_s_rdata[m*32 +: 32] !== (a ^ KEY)) begin
              errors++;
              $display("FAIL rand_rdata m%0d got=%h want=%h", m, r_s_rdata[m*32 +: 32], a ^ KEY);
            end
            checks++;
            if (total3 - snap > 8) begin
              errors++;
              $display("FAIL rand_fair m%0d got=%0d foreign transfers want<=8", m, total3 - snap);
            end
          end
          budget++;
          @(posedge clk); #1;
        end
        checks++;
        if (!done) begin
          errors++;
          $display("FAIL rand_timeout m%0d addr=%h got=no_ready want=ready", m, a);
        end
      end
      r_s_valid[m] = 1'b0;
    end
  endtask

  task automatic test_random_n3;
    idle(2);
    fork
      rmaster(0);
      rmaster(1);
      rmaster(2);
    join
    idle(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst_cap();
    test_wstrb();
    test_reset_mid();
    test_random_n3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
